// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt controller.
package irq_pkg;

   localparam int MAX_IRQ = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } irq_state_e;

   // Index of the first set bit in vec[0..n-1], scanning upward from offset
   // and wrapping at n. Returns 0 when nothing is set. offset must be < n.
   function automatic logic [4:0] first_set(input logic [MAX_IRQ-1:0] vec,
                                            input logic [5:0]         n,
                                            input logic [4:0]         offset);
      logic [5:0] idx;
      logic       found;
      first_set = '0;
      found     = 1'b0;
      for (int k = 0; k < MAX_IRQ; k++) begin
         idx = {1'b0, offset} + 6'(k);
         if (idx >= n) idx = idx - n;
         if (!found && (6'(k) < n) && vec[idx[4:0]]) begin
            first_set = idx[4:0];
            found     = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/irq_controller_if.sv
// CPU-side request/acknowledge/end-of-interrupt handshake.
interface irq_controller_if #(
   parameter int ID_W = 3
);
   logic            irq_req;
   logic [ID_W-1:0] irq_id;
   logic            irq_ack;
   logic            irq_eoi;

   modport master (output irq_req, irq_id, input irq_ack, irq_eoi);
   modport slave  (input irq_req, irq_id, output irq_ack, irq_eoi);
endinterface

// File: rtl/irq_sync_edge.sv
// One interrupt line: multi-stage synchroniser plus rising-edge detector.
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic nreset,
   input  logic async_in,
   output logic sync_o,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   dly_q, dly_d;

   // shift the raw input through the chain; keep one extra stage for edges
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
      dly_d  = sync_q[SYNC_STAGES-1];
   end

   // synchroniser and delay registers
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         dly_q  <= dly_d;
      end
   end

   assign sync_o = sync_q[SYNC_STAGES-1];
   assign rise_o = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/irq_controller.sv
// Vectored interrupt controller: synchronised, maskable edge/level channels
// with sticky pending bits and a req/ack/eoi handshake to the CPU.
// Optional build macro IRQ_ROUND_ROBIN_EN selects rotating priority
// (search starts after the last acknowledged channel); default is fixed
// lowest-index priority.
//
//   state   | meaning
//   IDLE    | arbitrating; latch winner when anything is eligible
//   REQ     | irq_req high, irq_id stable, waiting for ack
//   SERVICE | CPU handling irq_id, waiting for eoi (no nesting)
module irq_controller
   import irq_pkg::*;
#(
   parameter int NUM_IRQ     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               nreset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               mask_we,
   input  logic [NUM_IRQ-1:0] mask_d,
   input  logic               trig_we,
   input  logic [NUM_IRQ-1:0] trig_d,
   output logic [NUM_IRQ-1:0] pending_q,
   output logic [NUM_IRQ-1:0] mask_q,
   irq_controller_if.master   cpu
);

   localparam int ID_W = $clog2(NUM_IRQ);

   irq_state_e         state_q, state_d;
   logic [ID_W-1:0]    irq_id_q, irq_id_d;
   logic               irq_req_q, irq_req_d;
   logic [NUM_IRQ-1:0] pending_d;
   logic [NUM_IRQ-1:0] trig_q;
   logic [NUM_IRQ-1:0] level, rise;
   logic [NUM_IRQ-1:0] eligible;
   logic [MAX_IRQ-1:0] elig_wide;
   logic [ID_W-1:0]    winner;
   logic [4:0]         search_start;
   logic               ack_fire;

   for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
      irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk      (clk),
         .nreset   (nreset),
         .async_in (irq_in[i]),
         .sync_o   (level[i]),
         .rise_o   (rise[i])
      );
   end

`ifdef IRQ_ROUND_ROBIN_EN
   logic [ID_W-1:0] last_q, last_d;
   logic [5:0]      last_inc;

   // rotating search origin: one past the last acknowledged channel
   always_comb begin
      last_inc     = 6'(last_q) + 6'd1;
      search_start = (last_inc >= 6'(NUM_IRQ)) ? 5'd0 : last_inc[4:0];
      last_d       = ack_fire ? irq_id_q : last_q;
   end

   // last-served pointer
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) last_q <= '0;
      else         last_q <= last_d;
   end
`else
   assign search_start = 5'd0;
`endif

   // eligibility and priority winner
   always_comb begin
      eligible                = pending_q & mask_q;
      elig_wide               = '0;
      elig_wide[NUM_IRQ-1:0]  = eligible;
      winner                  = ID_W'(first_set(elig_wide, 6'(NUM_IRQ), search_start));
   end

   // handshake FSM next state and registered outputs
   always_comb begin
      state_d  = state_q;
      irq_id_d = irq_id_q;
      ack_fire = 1'b0;
      case (state_q)
         IDLE: begin
            if (|eligible) begin
               state_d  = REQ;
               irq_id_d = winner;
            end
         end
         REQ: begin
            if (cpu.irq_ack) begin
               state_d  = SERVICE;
               ack_fire = 1'b1;
            end else if (!eligible[irq_id_q]) begin
               state_d = IDLE;
            end
         end
         SERVICE: begin
            if (cpu.irq_eoi) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      irq_req_d = (state_d == REQ);
   end

   // pending update: edge channels are sticky until acked (a same-cycle
   // new edge keeps them set); level channels follow the synced input
   always_comb begin
      pending_d = pending_q;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (trig_q[i])
            pending_d[i] = (pending_q[i] & ~(ack_fire && (irq_id_q == ID_W'(i)))) | rise[i];
         else
            pending_d[i] = level[i];
      end
   end

   // state, pending and configuration registers
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q   <= IDLE;
         irq_id_q  <= '0;
         irq_req_q <= 1'b0;
         pending_q <= '0;
         mask_q    <= '0;
         trig_q    <= '1;
      end else begin
         state_q   <= state_d;
         irq_id_q  <= irq_id_d;
         irq_req_q <= irq_req_d;
         pending_q <= pending_d;
         if (mask_we) mask_q <= mask_d;
         if (trig_we) trig_q <= trig_d;
      end
   end

   assign cpu.irq_req = irq_req_q;
   assign cpu.irq_id  = irq_id_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller (NUM_IRQ=8, SYNC_STAGES=2).
module tb_irq_controller;

   logic       clk = 1'b0;
   logic       nreset = 1'b1;
   logic [7:0] irq_in = '0;
   logic       mask_we = 1'b0;
   logic [7:0] mask_d = '0;
   logic       trig_we = 1'b0;
   logic [7:0] trig_d = '0;
   logic [7:0] pending_q;
   logic [7:0] mask_q;
   int         n_tests = 0;
   int         n_fail  = 0;

`ifdef IRQ_ROUND_ROBIN_EN
   localparam int RR_ID   = 1;
   localparam int RR_LEFT = 8'h01;
`else
   localparam int RR_ID   = 0;
   localparam int RR_LEFT = 8'h02;
`endif

   irq_controller_if #(.ID_W(3)) cpu_if ();

   irq_controller #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .nreset    (nreset),
      .irq_in    (irq_in),
      .mask_we   (mask_we),
      .mask_d    (mask_d),
      .trig_we   (trig_we),
      .trig_d    (trig_d),
      .pending_q (pending_q),
      .mask_q    (mask_q),
      .cpu       (cpu_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int ch);
      irq_in[ch] = 1'b1;
      step(1);
      irq_in[ch] = 1'b0;
   endtask

   task automatic write_mask(input logic [7:0] v);
      mask_d  = v;
      mask_we = 1'b1;
      step(1);
      mask_we = 1'b0;
   endtask

   task automatic write_trig(input logic [7:0] v);
      trig_d  = v;
      trig_we = 1'b1;
      step(1);
      trig_we = 1'b0;
   endtask

   task automatic do_ack();
      cpu_if.irq_ack = 1'b1;
      step(1);
      cpu_if.irq_ack = 1'b0;
   endtask

   task automatic do_eoi();
      cpu_if.irq_eoi = 1'b1;
      step(1);
      cpu_if.irq_eoi = 1'b0;
   endtask

   initial begin
      cpu_if.irq_ack = 1'b0;
      cpu_if.irq_eoi = 1'b0;
      #1 nreset = 1'b0;
      #20;
      check("rst_pending", 32'(pending_q), 32'h0);
      check("rst_mask",    32'(mask_q),    32'h0);
      check("rst_req",     32'(cpu_if.irq_req), 32'h0);
      check("rst_id",      32'(cpu_if.irq_id),  32'h0);
      @(posedge clk); #1 nreset = 1'b1;
      step(1);

      write_mask(8'hFF);
      check("mask_wr", 32'(mask_q), 32'hFF);

      // basic edge on channel 3
      pulse(3);
      step(2);
      check("edge_pend",   32'(pending_q), 32'h08);
      check("edge_noreq",  32'(cpu_if.irq_req), 32'h0);
      step(1);
      check("edge_req",    32'(cpu_if.irq_req), 32'h1);
      check("edge_id",     32'(cpu_if.irq_id),  32'h3);
      do_ack();
      check("ack_pend",    32'(pending_q), 32'h0);
      check("ack_req",     32'(cpu_if.irq_req), 32'h0);
      check("ack_id",      32'(cpu_if.irq_id),  32'h3);
      do_ack();
      do_eoi();
      step(1);
      check("eoi_idle",    32'(cpu_if.irq_req), 32'h0);

      // priority: 2 and 5 together
      irq_in = 8'h24;
      step(1);
      irq_in = 8'h00;
      step(3);
      check("pri_req",     32'(cpu_if.irq_req), 32'h1);
      check("pri_id2",     32'(cpu_if.irq_id),  32'h2);
      do_eoi();
      check("pri_eoi_ign", 32'(cpu_if.irq_req), 32'h1);
      do_ack();
      check("pri_pend",    32'(pending_q), 32'h20);
      do_eoi();
      check("pri_gap",     32'(cpu_if.irq_req), 32'h0);
      step(1);
      check("pri_req5",    32'(cpu_if.irq_req), 32'h1);
      check("pri_id5",     32'(cpu_if.irq_id),  32'h5);
      do_ack();
      do_eoi();

      // masked pending is held, requested once unmasked
      write_mask(8'hF7);
      pulse(3);
      step(3);
      check("mask_pend",   32'(pending_q), 32'h08);
      check("mask_noreq",  32'(cpu_if.irq_req), 32'h0);
      write_mask(8'hFF);
      check("unmask_lat",  32'(cpu_if.irq_req), 32'h0);
      step(1);
      check("unmask_req",  32'(cpu_if.irq_req), 32'h1);
      check("unmask_id",   32'(cpu_if.irq_id),  32'h3);
      do_ack();
      do_eoi();

      // level mode on channel 0
      write_trig(8'hFE);
      irq_in[0] = 1'b1;
      step(3);
      check("lvl_pend",    32'(pending_q), 32'h01);
      step(1);
      check("lvl_req",     32'(cpu_if.irq_req), 32'h1);
      check("lvl_id",      32'(cpu_if.irq_id),  32'h0);
      do_ack();
      check("lvl_ack_pend", 32'(pending_q), 32'h01);
      do_eoi();
      step(1);
      check("lvl_rereq",   32'(cpu_if.irq_req), 32'h1);
      irq_in[0] = 1'b0;
      step(3);
      check("lvl_drop_pend", 32'(pending_q), 32'h0);
      check("lvl_drop_hold", 32'(cpu_if.irq_req), 32'h1);
      step(1);
      check("lvl_drop_req", 32'(cpu_if.irq_req), 32'h0);
      write_trig(8'hFF);

      // same-cycle re-arm on channel 4
      pulse(4);
      step(3);
      check("rearm_req",   32'(cpu_if.irq_id), 32'h4);
      pulse(4);
      step(1);
      do_ack();
      check("rearm_pend",  32'(pending_q), 32'h10);
      check("rearm_svc",   32'(cpu_if.irq_req), 32'h0);
      do_eoi();
      step(1);
      check("rearm_again", 32'(cpu_if.irq_req), 32'h1);
      do_ack();
      check("rearm_clr",   32'(pending_q), 32'h0);
      do_eoi();

      // channels 0 and 1 pending, 0 re-pends while being serviced
      irq_in = 8'h03;
      step(1);
      irq_in = 8'h00;
      step(3);
      check("rr_first",    32'(cpu_if.irq_id), 32'h0);
      do_ack();
      pulse(0);
      step(2);
      check("rr_pend",     32'(pending_q), 32'h03);
      do_eoi();
      step(1);
      check("rr_req",      32'(cpu_if.irq_req), 32'h1);
      check("rr_id",       32'(cpu_if.irq_id),  32'(RR_ID));
      do_ack();
      check("rr_left",     32'(pending_q), 32'(RR_LEFT));

      // asynchronous reset in SERVICE
      #2 nreset = 1'b0;
      #1;
      check("arst_req",    32'(cpu_if.irq_req), 32'h0);
      check("arst_pend",   32'(pending_q), 32'h0);
      check("arst_mask",   32'(mask_q),    32'h0);
      check("arst_id",     32'(cpu_if.irq_id), 32'h0);
      #2 nreset = 1'b1;
      @(posedge clk); #1;
      pulse(6);
      step(5);
      check("post_pend",   32'(pending_q), 32'h40);
      check("post_noreq",  32'(cpu_if.irq_req), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
